// File: rtl/rob_pkg.sv
// Shared types and constants for the reorder buffer: RISC-V opcodes, the
// commit FSM states and the layout of one buffer entry.
package rob_pkg;

  localparam logic [6:0] OPCODE_S    = 7'b0100011;
  localparam logic [6:0] OPCODE_BR   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_ST  = 2'd1,
    ROLLBACK = 2'd2
  } rob_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        pred_jump;
    logic [31:0] pred_target;
    logic [31:0] val;
    logic        res_jump;
    logic [31:0] res_pc;
    logic        ready;
  } rob_entry_t;

endpackage

// File: rtl/rob_cdb_bypass.sv
// Operand forwarding for one decoder query port: the stored entry is reported
// unless a valid broadcast channel hits the same position this cycle.
module rob_cdb_bypass #(
  parameter int POS_W   = 4,
  parameter int NUM_CDB = 2
) (
  input  logic [POS_W-1:0]         query_pos,
  input  logic                     entry_ready,
  input  logic [31:0]              entry_val,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*POS_W-1:0] cdb_pos,
  input  logic [NUM_CDB*32-1:0]    cdb_val,
  output logic                     ready,
  output logic [31:0]              val
);

  // Ascending scan so the highest-numbered matching channel wins.
  always_comb begin
    ready = entry_ready;
    val   = entry_val;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && cdb_pos[k*POS_W +: POS_W] == query_pos) begin
        ready = 1'b1;
        val   = cdb_val[k*32 +: 32];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer for the out-of-order core: issue at tail, results
// from the CDB, commit at head with store handshake and mispredict flush.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int POS_W   = $clog2(DEPTH),
  parameter int NUM_CDB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  output logic                     rob_nxt_full,
  output logic [POS_W-1:0]         nxt_rob_pos,
  output logic [POS_W-1:0]         head_rob_pos,
  input  logic                     issue,
  input  logic [4:0]               issue_rd,
  input  logic [6:0]               issue_opcode,
  input  logic [31:0]              issue_pc,
  input  logic                     issue_pred_jump,
  input  logic [31:0]              issue_pred_target,
  input  logic                     issue_is_ready,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*POS_W-1:0] cdb_pos,
  input  logic [NUM_CDB*32-1:0]    cdb_val,
  input  logic [NUM_CDB-1:0]       cdb_jump,
  input  logic [NUM_CDB*32-1:0]    cdb_pc,
  input  logic [POS_W-1:0]         rs1_pos,
  input  logic [POS_W-1:0]         rs2_pos,
  output logic                     rs1_ready,
  output logic                     rs2_ready,
  output logic [31:0]              rs1_val,
  output logic [31:0]              rs2_val,
  output logic [POS_W-1:0]         commit_rob_pos,
  output logic                     reg_write,
  output logic [4:0]               reg_rd,
  output logic [31:0]              reg_val,
  output logic                     lsb_store,
  input  logic                     lsb_store_done,
  output logic                     commit_br,
  output logic                     commit_br_jump,
  output logic [31:0]              commit_br_pc,
  output logic                     rollback,
  output logic                     if_set_pc_en,
  output logic [31:0]              if_set_pc
);

  localparam logic [POS_W:0] FULL_CNT = (POS_W+1)'(DEPTH);

  rob_entry_t       entry_reg [DEPTH];
  rob_entry_t       head_entry;
  rob_entry_t       issue_entry;
  rob_state_t       state_reg, state_next;
  logic [POS_W-1:0] head_reg, tail_reg;
  logic [POS_W:0]   count_reg, count_next;
  logic             do_commit, head_advance, go_rollback, issue_accept;

  assign head_entry   = entry_reg[head_reg];
  assign nxt_rob_pos  = tail_reg;
  assign head_rob_pos = head_reg;

  always_comb begin
    state_next   = state_reg;
    do_commit    = 1'b0;
    head_advance = 1'b0;
    go_rollback  = 1'b0;
    if (rdy) begin
      case (state_reg)
        RUN: begin
          if (count_reg != '0 && head_entry.ready) begin
            do_commit = 1'b1;
            if (head_entry.opcode == OPCODE_S) begin
              state_next = WAIT_ST;
            end else begin
              head_advance = 1'b1;
              if (head_entry.opcode == OPCODE_BR)
                go_rollback = (head_entry.res_jump != head_entry.pred_jump);
              else if (head_entry.opcode == OPCODE_JALR)
                go_rollback = (head_entry.res_pc != head_entry.pred_target);
              if (go_rollback)
                state_next = ROLLBACK;
            end
          end
        end
        WAIT_ST: begin
          if (lsb_store_done) begin
            head_advance = 1'b1;
            state_next   = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // A full buffer still accepts an issue when the head leaves in the same cycle.
  assign issue_accept = rdy && issue && (state_reg != ROLLBACK) &&
                        (count_reg != FULL_CNT || head_advance);
  assign count_next   = count_reg + (POS_W+1)'(issue_accept) - (POS_W+1)'(head_advance);
  assign rob_nxt_full = (count_next == FULL_CNT);

  always_comb begin
    issue_entry             = '0;
    issue_entry.rd          = issue_rd;
    issue_entry.opcode      = issue_opcode;
    issue_entry.pc          = issue_pc;
    issue_entry.pred_jump   = issue_pred_jump;
    issue_entry.pred_target = issue_pred_target;
    issue_entry.ready       = issue_is_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= RUN;
    else if (rdy) state_reg <= state_next;
  end

  // CDB writes follow the issue write so a broadcast wins on a shared position.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entry_reg[i] <= '0;
    end else if (rdy) begin
      if (state_reg == ROLLBACK) begin
        for (int i = 0; i < DEPTH; i++) entry_reg[i].ready <= 1'b0;
      end else begin
        if (issue_accept) entry_reg[tail_reg] <= issue_entry;
        for (int k = 0; k < NUM_CDB; k++) begin
          if (cdb_valid[k]) begin
            entry_reg[cdb_pos[k*POS_W +: POS_W]].val      <= cdb_val[k*32 +: 32];
            entry_reg[cdb_pos[k*POS_W +: POS_W]].res_jump <= cdb_jump[k];
            entry_reg[cdb_pos[k*POS_W +: POS_W]].res_pc   <= cdb_pc[k*32 +: 32];
            entry_reg[cdb_pos[k*POS_W +: POS_W]].ready    <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      commit_rob_pos <= '0;
      reg_write      <= 1'b0;
      reg_rd         <= '0;
      reg_val        <= '0;
      lsb_store      <= 1'b0;
      commit_br      <= 1'b0;
      commit_br_jump <= 1'b0;
      commit_br_pc   <= '0;
      rollback       <= 1'b0;
      if_set_pc_en   <= 1'b0;
      if_set_pc      <= '0;
    end else if (rdy) begin
      reg_write    <= 1'b0;
      lsb_store    <= 1'b0;
      commit_br    <= 1'b0;
      rollback     <= 1'b0;
      if_set_pc_en <= 1'b0;
      if (state_reg == ROLLBACK) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        count_reg <= count_next;
        if (head_advance) head_reg <= head_reg + POS_W'(1);
        if (issue_accept) tail_reg <= tail_reg + POS_W'(1);
        if (do_commit) begin
          commit_rob_pos <= head_reg;
          if (head_entry.opcode == OPCODE_S) begin
            lsb_store <= 1'b1;
          end else if (head_entry.opcode == OPCODE_BR) begin
            commit_br      <= 1'b1;
            commit_br_jump <= head_entry.res_jump;
            commit_br_pc   <= head_entry.pc;
          end else begin
            reg_write <= 1'b1;
            reg_rd    <= head_entry.rd;
            reg_val   <= head_entry.val;
          end
        end
        if (go_rollback) begin
          rollback     <= 1'b1;
          if_set_pc_en <= 1'b1;
          if_set_pc    <= head_entry.res_pc;
        end
      end
    end
  end

  rob_cdb_bypass #(.POS_W(POS_W), .NUM_CDB(NUM_CDB)) u_bypass_rs1 (
    .query_pos   (rs1_pos),
    .entry_ready (entry_reg[rs1_pos].ready),
    .entry_val   (entry_reg[rs1_pos].val),
    .cdb_valid   (cdb_valid),
    .cdb_pos     (cdb_pos),
    .cdb_val     (cdb_val),
    .ready       (rs1_ready),
    .val         (rs1_val)
  );

  rob_cdb_bypass #(.POS_W(POS_W), .NUM_CDB(NUM_CDB)) u_bypass_rs2 (
    .query_pos   (rs2_pos),
    .entry_ready (entry_reg[rs2_pos].ready),
    .entry_val   (entry_reg[rs2_pos].val),
    .cdb_valid   (cdb_valid),
    .cdb_pos     (cdb_pos),
    .cdb_val     (cdb_val),
    .ready       (rs2_ready),
    .val         (rs2_val)
  );

endmodule
